// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit LFSR byte generator: lock detection, error pulses, saturating error count.
// Optional LFSR_CHK_SEG_EN adds active-low hex 7-segment decoders for err_cnt on seg0/seg1.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic [7:0] expected,
    output logic [7:0] seg0,
    output logic [7:0] seg1
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t     state;
    logic [7:0] seed;
    logic       seed_ok;
    logic [3:0] run;
    logic [3:0] miss;

    function automatic logic [7:0] nxt(input logic [7:0] d);
        if (d == 8'h00) return 8'h01;
        return {d[4] ^ d[3] ^ d[2] ^ d[0], d[7:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            seed      <= '0;
            seed_ok   <= 1'b0;
            run       <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            expected  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        seed <= in_data;
                        if (!seed_ok) begin
                            seed_ok <= 1'b1;
                            run     <= '0;
                        end else if (in_data == nxt(seed)) begin
                            run <= run + 4'd1;
                            if (run + 4'd1 == LOCK_N) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                expected <= nxt(in_data);
                                miss     <= '0;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: prediction advances regardless of what arrived.
                        expected <= nxt(expected);
                        if (in_data == expected) begin
                            miss <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                            miss <= miss + 4'd1;
                            if (miss + 4'd1 == LOSS_N) begin
                                state   <= SEARCH;
                                locked  <= 1'b0;
                                seed    <= in_data;
                                seed_ok <= 1'b1;
                                run     <= '0;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

`ifdef LFSR_CHK_SEG_EN
    // Bits 7..1 = segments a..g, bit 0 = dp; a 0 lights the segment.
    function automatic logic [7:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 8'h03;
            4'h1: return 8'h9F;
            4'h2: return 8'h25;
            4'h3: return 8'h0D;
            4'h4: return 8'h99;
            4'h5: return 8'h49;
            4'h6: return 8'h41;
            4'h7: return 8'h1F;
            4'h8: return 8'h01;
            4'h9: return 8'h09;
            4'hA: return 8'h11;
            4'hB: return 8'hC1;
            4'hC: return 8'h63;
            4'hD: return 8'h85;
            4'hE: return 8'h61;
            default: return 8'h71;
        endcase
    endfunction

    always_comb begin
        seg0 = hex7(err_cnt[3:0]);
        seg1 = hex7(err_cnt[7:4]);
    end
`else
    always_comb begin
        seg0 = '1;
        seg1 = '1;
    end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed self-checking bench for lfsr_checker; seg expectations follow LFSR_CHK_SEG_EN.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] expected;
    logic [7:0] seg0;
    logic [7:0] seg1;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LFSR_CHK_SEG_EN
    localparam bit SEG_ON = 1'b1;
`else
    localparam bit SEG_ON = 1'b0;
`endif

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .expected  (expected),
        .seg0      (seg0),
        .seg1      (seg1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic beat(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Reference next-value: feedback = parity of taps 4,3,2,0.
    function automatic logic [7:0] ref_nxt(input logic [7:0] d);
        if (d == 8'h00) return 8'h01;
        return {^(d & 8'h1D), d[7:1]};
    endfunction

    logic [7:0] exp_m;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", {7'd0, locked}, 8'h00);
        check("rst_pulse", {7'd0, err_pulse}, 8'h00);
        check("rst_errcnt", err_cnt, 8'h00);
        check("rst_expected", expected, 8'h00);
        check("rst_seg0", seg0, SEG_ON ? 8'h03 : 8'hFF);
        check("rst_seg1", seg1, SEG_ON ? 8'h03 : 8'hFF);
        @(negedge clk); rst = 1'b0;

        // Lock on 01,80,40,20,10
        beat(1, 8'h01);
        beat(1, 8'h80);
        beat(1, 8'h40);
        beat(1, 8'h20);
        check("lock_not_yet", {7'd0, locked}, 8'h00);
        beat(1, 8'h10);
        check("lock_locked", {7'd0, locked}, 8'h01);
        check("lock_expected", expected, 8'h88);
        check("lock_errcnt", err_cnt, 8'h00);

        // Single error
        beat(1, 8'h00);
        check("err1_pulse", {7'd0, err_pulse}, 8'h01);
        check("err1_cnt", err_cnt, 8'h01);
        check("err1_expected", expected, 8'hC4);
        check("err1_seg0", seg0, SEG_ON ? 8'h9F : 8'hFF);
        check("err1_locked", {7'd0, locked}, 8'h01);
        beat(0, 8'h00);
        check("idle_pulse_clear", {7'd0, err_pulse}, 8'h00);
        check("idle_expected_hold", expected, 8'hC4);
        beat(1, 8'hC4);
        check("recover_pulse", {7'd0, err_pulse}, 8'h00);
        check("recover_locked", {7'd0, locked}, 8'h01);
        check("recover_expected", expected, 8'hE2);

        // Loss of lock: three wrong bytes (expected E2,71,38)
        beat(1, 8'hFF);
        check("loss1_pulse", {7'd0, err_pulse}, 8'h01);
        check("loss1_locked", {7'd0, locked}, 8'h01);
        beat(1, 8'hFF);
        check("loss2_pulse", {7'd0, err_pulse}, 8'h01);
        check("loss2_locked", {7'd0, locked}, 8'h01);
        beat(1, 8'hFF);
        check("loss3_pulse", {7'd0, err_pulse}, 8'h01);
        check("loss3_cnt", err_cnt, 8'h04);
        check("loss3_locked", {7'd0, locked}, 8'h00);

        // Relock: seed FF predicts 7F, so 01 reseeds, then four matches
        beat(1, 8'h01);
        beat(1, 8'h80);
        beat(1, 8'h40);
        beat(1, 8'h20);
        check("relock_not_yet", {7'd0, locked}, 8'h00);
        check("search_no_err", err_cnt, 8'h04);
        beat(1, 8'h10);
        check("relock_locked", {7'd0, locked}, 8'h01);
        check("relock_expected", expected, 8'h88);

        beat(1, 8'h33);
        check("err5_cnt", err_cnt, 8'h05);
        check("err5_seg0", seg0, SEG_ON ? 8'h49 : 8'hFF);
        check("err5_seg1", seg1, SEG_ON ? 8'h03 : 8'hFF);

        // Mid-stream reset with a valid beat in the same cycle
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hC4;
        @(posedge clk); #1;
        check("mrst_locked", {7'd0, locked}, 8'h00);
        check("mrst_pulse", {7'd0, err_pulse}, 8'h00);
        check("mrst_errcnt", err_cnt, 8'h00);
        check("mrst_expected", expected, 8'h00);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;

        // Zero seed with gaps: 00 then 01 must count as a match
        beat(1, 8'h00);
        repeat (5) begin
            beat(0, 8'hAA);
            check("gap_locked", {7'd0, locked}, 8'h00);
        end
        beat(1, 8'h01);
        repeat (5) beat(0, 8'h55);
        beat(1, 8'h80);
        beat(1, 8'h40);
        check("zero_not_yet", {7'd0, locked}, 8'h00);
        beat(1, 8'h20);
        check("zero_locked", {7'd0, locked}, 8'h01);
        check("zero_expected", expected, 8'h10);

        // Saturation: alternate wrong/right so lock is never lost
        exp_m = 8'h10;
        for (int i = 0; i < 260; i++) begin
            beat(1, exp_m ^ 8'h5A);
            exp_m = ref_nxt(exp_m);
            beat(1, exp_m);
            exp_m = ref_nxt(exp_m);
        end
        check("sat_errcnt", err_cnt, 8'hFF);
        check("sat_locked", {7'd0, locked}, 8'h01);
        check("sat_expected", expected, exp_m);
        check("sat_seg0", seg0, SEG_ON ? 8'h71 : 8'hFF);
        check("sat_seg1", seg1, SEG_ON ? 8'h71 : 8'hFF);
        beat(1, exp_m ^ 8'h01);
        check("sat_pulse", {7'd0, err_pulse}, 8'h01);
        check("sat_hold", err_cnt, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
